obi_mux_3_to_1: RTL



---
 rtl/obi_mux_pkg.sv | 35 +++
 rtl/obi_mux_route_fifo.sv | 67 ++++++
 rtl/obi_mux_3_to_1.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/obi_mux_pkg.sv
// Shared definitions for the 3-to-1 arbitrating OBI mux.
//   ctrl_sel_e   : controller index encoding (CTRL_NONE = no winner)
//   obi_aphase_t : OBI address-phase payload (addr, we, be, wdata)
//   sel_req()    : request bit of the controller selected by an index
package obi_mux_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [SEL_W-1:0] {
        CTRL_NONE = 2'd0,
        CTRL_1    = 2'd1,
        CTRL_2    = 2'd2,
        CTRL_3    = 2'd3
    } ctrl_sel_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } obi_aphase_t;

    function automatic logic sel_req(input ctrl_sel_e sel, input logic [2:0] req);
        case (sel)
            CTRL_1:  return req[0];
            CTRL_2:  return req[1];
            CTRL_3:  return req[2];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/obi_mux_route_fifo.sv
// In-order routing FIFO: remembers which controller owns each outstanding
// transaction so responses can be steered back.
//   clk_i, rst_ni : clock, async active-low reset
//   push, data_in : enqueue an entry (accepted when not full, or when popping)
//   pop           : dequeue the head (ignored when empty)
//   full, empty   : occupancy flags from the registered count
//   head          : oldest entry
module obi_mux_route_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obi_mux_3_to_1.sv
// Arbitrating OBI mux: three OBI controllers share one OBI slave port.
// Request and response paths are combinational from state (zero added
// latency); a routing FIFO steers in-order responses back to their owner.
// Build option: OBI_MUX_ROUND_ROBIN_EN selects round-robin arbitration;
// without it arbitration is fixed priority ctrl1 > ctrl2 > ctrl3.
//   ctrlN_*        : controller-side OBI ports (N = 1..3)
//   port_*         : shared slave-side OBI port
//   illegal_resp_o : response arrived with nothing outstanding (dropped)
module obi_mux_3_to_1
    import obi_mux_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ctrl1_req_i,
    output logic              ctrl1_gnt_o,
    input  logic [ADDR_W-1:0] ctrl1_addr_i,
    input  logic              ctrl1_we_i,
    input  logic [BE_W-1:0]   ctrl1_be_i,
    input  logic [DATA_W-1:0] ctrl1_wdata_i,
    output logic              ctrl1_rvalid_o,
    output logic [DATA_W-1:0] ctrl1_rdata_o,
    input  logic              ctrl2_req_i,
    output logic              ctrl2_gnt_o,
    input  logic [ADDR_W-1:0] ctrl2_addr_i,
    input  logic              ctrl2_we_i,
    input  logic [BE_W-1:0]   ctrl2_be_i,
    input  logic [DATA_W-1:0] ctrl2_wdata_i,
    output logic              ctrl2_rvalid_o,
    output logic [DATA_W-1:0] ctrl2_rdata_o,
    input  logic              ctrl3_req_i,
    output logic              ctrl3_gnt_o,
    input  logic [ADDR_W-1:0] ctrl3_addr_i,
    input  logic              ctrl3_we_i,
    input  logic [BE_W-1:0]   ctrl3_be_i,
    input  logic [DATA_W-1:0] ctrl3_wdata_i,
    output logic              ctrl3_rvalid_o,
    output logic [DATA_W-1:0] ctrl3_rdata_o,
    output logic              port_req_o,
    input  logic              port_gnt_i,
    output logic [ADDR_W-1:0] port_addr_o,
    output logic              port_we_o,
    output logic [BE_W-1:0]   port_be_o,
    output logic [DATA_W-1:0] port_wdata_o,
    input  logic              port_rvalid_i,
    input  logic [DATA_W-1:0] port_rdata_i,
    output logic              illegal_resp_o
);

    logic [2:0]      req_vec;
    ctrl_sel_e       arb_sel;
    ctrl_sel_e       winner;
    ctrl_sel_e       lock_sel_q;
    logic            lock_q;
    obi_aphase_t     sel_aph;
    logic            fifo_full;
    logic            fifo_empty;
    logic [SEL_W-1:0] fifo_head;
    logic            accept;
    logic            resp_pop;
    ctrl_sel_e       resp_sel;

    assign req_vec = {ctrl3_req_i, ctrl2_req_i, ctrl1_req_i};

`ifdef OBI_MUX_ROUND_ROBIN_EN
    ctrl_sel_e last_q;

    // Search starts just after the most recently accepted controller.
    always_comb begin
        arb_sel = CTRL_NONE;
        case (last_q)
            CTRL_1: begin
                if      (req_vec[1]) arb_sel = CTRL_2;
                else if (req_vec[2]) arb_sel = CTRL_3;
                else if (req_vec[0]) arb_sel = CTRL_1;
            end
            CTRL_2: begin
                if      (req_vec[2]) arb_sel = CTRL_3;
                else if (req_vec[0]) arb_sel = CTRL_1;
                else if (req_vec[1]) arb_sel = CTRL_2;
            end
            default: begin
                if      (req_vec[0]) arb_sel = CTRL_1;
                else if (req_vec[1]) arb_sel = CTRL_2;
                else if (req_vec[2]) arb_sel = CTRL_3;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= CTRL_3;
        end else if (accept) begin
            last_q <= winner;
        end
    end
`else
    always_comb begin
        arb_sel = CTRL_NONE;
        if      (req_vec[0]) arb_sel = CTRL_1;
        else if (req_vec[1]) arb_sel = CTRL_2;
        else if (req_vec[2]) arb_sel = CTRL_3;
    end
`endif

    // A stalled address phase keeps its controller; if that controller
    // withdraws its request there is no winner and the lock lapses.
    always_comb begin
        winner = arb_sel;
        if (lock_q) begin
            winner = sel_req(lock_sel_q, req_vec) ? lock_sel_q : CTRL_NONE;
        end
    end

    assign port_req_o = (winner != CTRL_NONE) && !fifo_full;
    assign accept     = port_req_o && port_gnt_i;

    assign ctrl1_gnt_o = (winner == CTRL_1) && port_gnt_i && !fifo_full;
    assign ctrl2_gnt_o = (winner == CTRL_2) && port_gnt_i && !fifo_full;
    assign ctrl3_gnt_o = (winner == CTRL_3) && port_gnt_i && !fifo_full;

    // Address-phase mux; all zero when nobody is selected.
    always_comb begin
        sel_aph = '0;
        case (winner)
            CTRL_1:  sel_aph = {ctrl1_addr_i, ctrl1_we_i, ctrl1_be_i, ctrl1_wdata_i};
            CTRL_2:  sel_aph = {ctrl2_addr_i, ctrl2_we_i, ctrl2_be_i, ctrl2_wdata_i};
            CTRL_3:  sel_aph = {ctrl3_addr_i, ctrl3_we_i, ctrl3_be_i, ctrl3_wdata_i};
            default: sel_aph = '0;
        endcase
    end

    assign port_addr_o  = sel_aph.addr;
    assign port_we_o    = sel_aph.we;
    assign port_be_o    = sel_aph.be;
    assign port_wdata_o = sel_aph.wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_sel_q <= CTRL_NONE;
        end else begin
            lock_q <= port_req_o && !port_gnt_i;
            if (port_req_o && !port_gnt_i) begin
                lock_sel_q <= winner;
            end
        end
    end

    obi_mux_route_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (SEL_W)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (accept),
        .data_in (winner),
        .pop     (resp_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Responses return in issue order; the FIFO head names the owner.
    assign resp_pop       = port_rvalid_i && !fifo_empty;
    assign resp_sel       = ctrl_sel_e'(fifo_head);
    assign illegal_resp_o = port_rvalid_i && fifo_empty;

    assign ctrl1_rvalid_o = resp_pop && (resp_sel == CTRL_1);
    assign ctrl2_rvalid_o = resp_pop && (resp_sel == CTRL_2);
    assign ctrl3_rvalid_o = resp_pop && (resp_sel == CTRL_3);

    assign ctrl1_rdata_o = port_rdata_i;
    assign ctrl2_rdata_o = port_rdata_i;
    assign ctrl3_rdata_o = port_rdata_i;

endmodule
